// File: rtl/ac_zone_scheduler.sv
// Round-robin arbiter sharing one heating/cooling plant between NZONE zones,
// with minimum/maximum run time and a plant-off dead time between grants.
module ac_zone_scheduler #(
    parameter int unsigned NZONE   = 4,
    parameter int unsigned MIN_RUN = 8,
    parameter int unsigned MAX_RUN = 32,
    parameter int unsigned DEAD    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NZONE-1:0] heat_req,
    input  logic [NZONE-1:0] cool_req,
    output logic [NZONE-1:0] zone_grant,
    output logic             plant_heat,
    output logic             plant_cool,
    output logic             busy
);
    localparam int unsigned LW   = $clog2(NZONE);
    localparam int unsigned SW   = LW + 1;
    localparam int unsigned CMAX = (MAX_RUN > DEAD) ? MAX_RUN : DEAD;
    localparam int unsigned CW   = $clog2(CMAX + 1);

    localparam logic [CW-1:0] MIN_C  = CW'(MIN_RUN);
    localparam logic [CW-1:0] MAX_C  = CW'(MAX_RUN);
    localparam logic [CW-1:0] DEAD_C = CW'(DEAD);
    localparam logic [CW-1:0] ONE_C  = CW'(1);
    localparam logic [LW-1:0] LAST_Z = LW'(NZONE - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DEAD = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [LW-1:0]   last_q, last_d;
    logic            mode_heat_q, mode_heat_d;
    logic [NZONE-1:0] grant_d;
    logic            heat_d, cool_d, busy_d;

    logic [NZONE-1:0] active;
    logic [NZONE-1:0] own_mask;
    logic [LW-1:0]   sel;
    logic            found;
    logic [SW-1:0]   cand;
    logic            own_req;
    logic            others;
    logic            release_run;

    assign active = heat_req | cool_req;

    // First active zone searching upward from last+1, wrapping modulo NZONE.
    always_comb begin
        sel   = last_q;
        found = 1'b0;
        cand  = '0;
        for (int i = 1; i <= int'(NZONE); i++) begin
            cand = SW'(last_q) + SW'(i);
            if (cand >= SW'(NZONE)) begin
                cand = cand - SW'(NZONE);
            end
            if (!found && active[cand[LW-1:0]]) begin
                found = 1'b1;
                sel   = cand[LW-1:0];
            end
        end
    end

    // Release decision for the zone currently holding the plant.
    always_comb begin
        own_mask         = '0;
        own_mask[last_q] = 1'b1;
        own_req          = mode_heat_q ? heat_req[last_q] : cool_req[last_q];
        others           = |(active & ~own_mask);
        release_run      = ((cnt_q >= MIN_C) && !own_req) ||
                           ((cnt_q >= MAX_C) && others);
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_d      = last_q;
        mode_heat_d = mode_heat_q;
        grant_d     = '0;
        heat_d      = 1'b0;
        cool_d      = 1'b0;
        busy_d      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (found) begin
                    state_d     = S_RUN;
                    last_d      = sel;
                    mode_heat_d = heat_req[sel];
                    cnt_d       = ONE_C;
                end
            end
            S_RUN: begin
                if (release_run) begin
                    state_d = S_DEAD;
                    cnt_d   = ONE_C;
                end else if (cnt_q < MAX_C) begin
                    cnt_d = cnt_q + ONE_C;
                end
            end
            S_DEAD: begin
                if (cnt_q >= DEAD_C) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ONE_C;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        if (state_d == S_RUN) begin
            grant_d[last_d] = 1'b1;
            heat_d          = mode_heat_d;
            cool_d          = !mode_heat_d;
        end
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            last_q      <= LAST_Z;
            mode_heat_q <= 1'b0;
            zone_grant  <= '0;
            plant_heat  <= 1'b0;
            plant_cool  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            mode_heat_q <= mode_heat_d;
            zone_grant  <= grant_d;
            plant_heat  <= heat_d;
            plant_cool  <= cool_d;
            busy        <= busy_d;
        end
    end
endmodule

// File: tb/tb_ac_zone_scheduler.sv
// Bench for ac_zone_scheduler: directed scenarios plus random request traffic,
// every cycle compared against a zone-level reference model.
module tb_ac_zone_scheduler;
    localparam int unsigned NZ   = 4;
    localparam int unsigned MINR = 8;
    localparam int unsigned MAXR = 32;
    localparam int unsigned DT   = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [NZ-1:0] heat_req;
    logic [NZ-1:0] cool_req;
    logic [NZ-1:0] zone_grant;
    logic          plant_heat;
    logic          plant_cool;
    logic          busy;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ac_zone_scheduler #(
        .NZONE(NZ), .MIN_RUN(MINR), .MAX_RUN(MAXR), .DEAD(DT)
    ) dut (
        .clk(clk), .rst(rst), .heat_req(heat_req), .cool_req(cool_req),
        .zone_grant(zone_grant), .plant_heat(plant_heat),
        .plant_cool(plant_cool), .busy(busy)
    );

    // Reference: which zone owns the plant, for how long, and dead time left.
    int m_owner;
    int m_on;
    int m_dead;
    int m_last;
    bit m_heat;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_step(input logic [NZ-1:0] h, input logic [NZ-1:0] c, input logic r);
        logic [NZ-1:0] act;
        bit own;
        bit others;
        int z;
        act = h | c;
        if (r) begin
            m_owner = -1;
            m_on    = 0;
            m_dead  = 0;
            m_last  = NZ - 1;
            m_heat  = 1'b0;
        end else if (m_owner >= 0) begin
            own    = m_heat ? h[m_owner] : c[m_owner];
            others = 1'b0;
            for (int k = 0; k < int'(NZ); k++)
                if (k != m_owner && act[k]) others = 1'b1;
            if ((m_on >= int'(MINR) && !own) || (m_on >= int'(MAXR) && others)) begin
                m_owner = -1;
                m_dead  = DT;
            end else begin
                m_on++;
            end
        end else if (m_dead > 0) begin
            m_dead--;
        end else begin
            for (int i = 1; i <= int'(NZ); i++) begin
                z = (m_last + i) % NZ;
                if (act[z]) begin
                    m_owner = z;
                    m_last  = z;
                    m_heat  = h[z];
                    m_on    = 1;
                    break;
                end
            end
        end
    endtask

    task automatic cycle(input logic [NZ-1:0] h, input logic [NZ-1:0] c, input logic r);
        logic [31:0] eg;
        heat_req = h;
        cool_req = c;
        rst      = r;
        @(posedge clk);
        model_step(h, c, r);
        #1;
        eg = (m_owner >= 0) ? 32'(1 << m_owner) : 32'd0;
        check_eq("zone_grant", 32'(zone_grant), eg);
        check_eq("plant_heat", 32'(plant_heat), 32'(m_owner >= 0 && m_heat));
        check_eq("plant_cool", 32'(plant_cool), 32'(m_owner >= 0 && !m_heat));
        check_eq("busy", 32'(busy), 32'(m_owner >= 0 || m_dead > 0));
        check_eq("heat_cool_excl", 32'(plant_heat & plant_cool), 32'd0);
    endtask

    task automatic idle_gap(input int n);
        for (int i = 0; i < n; i++) cycle('0, '0, 1'b0);
    endtask

    int n_on, n_off, run, best0, best3;
    bit saw;
    logic [NZ-1:0] rh, rc;
    int len;
    logic rr;

    initial begin
        heat_req = '0;
        cool_req = '0;
        rst      = 1'b1;
        m_owner = -1; m_on = 0; m_dead = 0; m_last = NZ - 1; m_heat = 1'b0;

        cycle('0, '0, 1'b1);
        cycle('0, '0, 1'b1);
        check_eq("reset_grant", 32'(zone_grant), 32'd0);
        check_eq("reset_busy", 32'(busy), 32'd0);
        idle_gap(2);

        // Zone 2 heat for 3 cycles: full MIN_RUN grant, then dead time.
        n_on = 0; n_off = 0;
        for (int i = 0; i < 25; i++) begin
            cycle((i < 3) ? 4'b0100 : 4'b0000, '0, 1'b0);
            if (zone_grant == 4'b0100 && plant_heat) n_on++;
            if (busy && zone_grant == '0) n_off++;
        end
        check_eq("s_min_run_len", 32'(n_on), 32'(MINR));
        check_eq("s_dead_len", 32'(n_off), 32'(DT));

        // Zones 0 and 3 cool continuously: alternating MAX_RUN grants.
        best0 = 0; best3 = 0; run = 0;
        for (int i = 0; i < 160; i++) begin
            cycle('0, 4'b1001, 1'b0);
            if (zone_grant != '0 && zone_grant == dut.zone_grant) run = (i > 0 && run > 0 && zone_grant == zone_grant) ? run : run;
            if (zone_grant == 4'b0001) begin best0 = (run + 1 > best0 && plant_cool) ? run + 1 : best0; run++; end
            else if (zone_grant == 4'b1000) begin best3 = (run + 1 > best3) ? run + 1 : best3; run++; end
            else run = 0;
        end
        check_eq("s_rr_run_z0", 32'(best0), 32'(MAXR));
        check_eq("s_rr_run_z3", 32'(best3), 32'(MAXR));
        idle_gap(20);

        // Single requester held 100 cycles: never pre-empted.
        n_on = 0;
        for (int i = 0; i < 110; i++) begin
            cycle((i < 100) ? 4'b0010 : 4'b0000, '0, 1'b0);
            if (zone_grant == 4'b0010) n_on++;
        end
        check_eq("s_single_len", 32'(n_on), 32'd100);
        idle_gap(5);

        // Zone 0 flips heat to cool: release, dead time, new cool grant.
        saw = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (i < 10) cycle(4'b0001, '0, 1'b0);
            else        cycle('0, 4'b0001, 1'b0);
            if (zone_grant == 4'b0001 && plant_cool) saw = 1'b1;
        end
        check_eq("s_mode_switch_cool", 32'(saw), 32'd1);
        idle_gap(20);

        // Zone 1 heat and cool together: heat wins.
        cycle(4'b0010, 4'b0010, 1'b0);
        check_eq("s_both_heat", 32'(plant_heat), 32'd1);
        check_eq("s_both_cool", 32'(plant_cool), 32'd0);
        for (int i = 0; i < 10; i++) cycle(4'b0010, 4'b0010, 1'b0);
        idle_gap(20);

        // Reset mid-RUN at counter 5, pointer returns so zone 0 wins.
        for (int i = 0; i < 5; i++) cycle(4'b0010, '0, 1'b0);
        cycle(4'b0011, '0, 1'b1);
        check_eq("s_rst_grant", 32'(zone_grant), 32'd0);
        check_eq("s_rst_busy", 32'(busy), 32'd0);
        cycle(4'b0011, '0, 1'b0);
        check_eq("s_rst_rr_zone0", 32'(zone_grant), 32'd1);
        for (int i = 0; i < 10; i++) cycle(4'b0011, '0, 1'b0);
        idle_gap(20);

        // Random traffic with occasional resets.
        for (int s = 0; s < 80; s++) begin
            rh  = NZ'($urandom_range(0, 15)) & NZ'($urandom_range(0, 15));
            rc  = NZ'($urandom_range(0, 15)) & NZ'($urandom_range(0, 15));
            len = $urandom_range(1, 50);
            rr  = ($urandom_range(0, 19) == 0);
            for (int i = 0; i < len; i++) cycle(rh, rc, (i == 0) ? rr : 1'b0);
        end
        idle_gap(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
